// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared playfield geometry, ball constants and FSM encoding
package pong_pkg;

  // One sign bit and headroom so paddle row + PAD_H never wraps.
  typedef logic signed [11:0] coord_t;

  localparam coord_t BALL_SIZE   = 12'sd12;
  localparam coord_t SPEED       = 12'sd2;
  localparam coord_t TOP_Y       = 12'sd11;
  localparam coord_t BOTTOM_Y    = 12'sd469;
  localparam coord_t LPAD_X      = 12'sd40;
  localparam coord_t RPAD_X      = 12'sd600;
  localparam coord_t PAD_H       = 12'sd100;
  localparam coord_t LEFT_LIMIT  = 12'sd10;
  localparam coord_t RIGHT_LIMIT = 12'sd630;
  localparam coord_t CENTER_X    = 12'sd314;
  localparam coord_t CENTER_Y    = 12'sd234;

  localparam logic [5:0] SERVE_DELAY = 6'd60;
  localparam logic [2:0] LIVES_INIT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_OVER
  } state_t;

  function automatic coord_t to_coord(input logic [9:0] v);
    return {2'b00, v};
  endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// rtl/pong_ball_engine_if.sv - frame/paddle inputs and ball/lives outputs of the ball engine
interface pong_ball_engine_if;

  logic       frame_tick;
  logic       start;
  logic [9:0] posbarraiy;
  logic [9:0] posbarrady;
  logic [9:0] posx;
  logic [9:0] posy;
  logic [2:0] vidasi;
  logic [2:0] vidasd;
  logic       game_over;
  logic       hit;

  modport master (
    output frame_tick, start, posbarraiy, posbarrady,
    input  posx, posy, vidasi, vidasd, game_over, hit
  );

  modport slave (
    input  frame_tick, start, posbarraiy, posbarrady,
    output posx, posy, vidasi, vidasd, game_over, hit
  );

endinterface

// File: rtl/pong_collide.sv
// rtl/pong_collide.sv - one-frame ball step with wall/paddle bounces and miss detection
module pong_collide
  import pong_pkg::*;
(
  input  coord_t pos_x,
  input  coord_t pos_y,
  input  logic   dx_neg,
  input  logic   dy_neg,
  input  coord_t pad_l_y,
  input  coord_t pad_r_y,
  output coord_t next_x,
  output coord_t next_y,
  output logic   next_dx_neg,
  output logic   next_dy_neg,
  output logic   hit_l,
  output logic   hit_r,
  output logic   miss_l,
  output logic   miss_r
);

  coord_t raw_x;
  coord_t raw_y;
  logic   ovl_l;
  logic   ovl_r;

  always_comb begin
    raw_x       = dx_neg ? pos_x - SPEED : pos_x + SPEED;
    raw_y       = dy_neg ? pos_y - SPEED : pos_y + SPEED;
    next_y      = raw_y;
    next_dy_neg = dy_neg;
    if (raw_y <= TOP_Y) begin
      next_y      = TOP_Y;
      next_dy_neg = 1'b0;
    end else if (raw_y + BALL_SIZE >= BOTTOM_Y) begin
      next_y      = BOTTOM_Y - BALL_SIZE;
      next_dy_neg = 1'b1;
    end

    // Overlap uses the wall-corrected row so a corner bounce still meets the paddle.
    ovl_l = (next_y + BALL_SIZE > pad_l_y) && (next_y < pad_l_y + PAD_H);
    ovl_r = (next_y + BALL_SIZE > pad_r_y) && (next_y < pad_r_y + PAD_H);

    hit_l = dx_neg && (pos_x > LPAD_X) && (raw_x <= LPAD_X) && ovl_l;
    hit_r = !dx_neg && (pos_x + BALL_SIZE < RPAD_X) &&
            (raw_x + BALL_SIZE >= RPAD_X) && ovl_r;

    next_x      = raw_x;
    next_dx_neg = dx_neg;
    if (hit_l) begin
      next_x      = LPAD_X + 12'sd1;
      next_dx_neg = 1'b0;
    end else if (hit_r) begin
      next_x      = RPAD_X - BALL_SIZE - 12'sd1;
      next_dx_neg = 1'b1;
    end

    miss_l = !hit_l && (raw_x <= LEFT_LIMIT);
    miss_r = !hit_r && (raw_x + BALL_SIZE >= RIGHT_LIMIT);
  end

endmodule

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - per-frame ball motion, scoring and serve/game FSM
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  pong_ball_engine_if.slave    bus
);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       dxn_q, dxn_d;
  logic       dyn_q, dyn_d;
  logic [2:0] li_q, li_d;
  logic [2:0] ld_q, ld_d;
  logic       go_q, go_d;
  logic       hit_q, hit_d;

  coord_t c_x, c_y;
  logic   c_dxn, c_dyn;
  logic   c_hit_l, c_hit_r, c_miss_l, c_miss_r;

  pong_collide u_collide (
    .pos_x       (x_q),
    .pos_y       (y_q),
    .dx_neg      (dxn_q),
    .dy_neg      (dyn_q),
    .pad_l_y     (to_coord(bus.posbarraiy)),
    .pad_r_y     (to_coord(bus.posbarrady)),
    .next_x      (c_x),
    .next_y      (c_y),
    .next_dx_neg (c_dxn),
    .next_dy_neg (c_dyn),
    .hit_l       (c_hit_l),
    .hit_r       (c_hit_r),
    .miss_l      (c_miss_l),
    .miss_r      (c_miss_r)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    li_d    = li_q;
    ld_d    = ld_q;
    hit_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_DELAY;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == 6'd0) state_d = ST_PLAY;
          else               cnt_d   = cnt_q - 6'd1;
        end
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          x_d   = c_x;
          y_d   = c_y;
          dxn_d = c_dxn;
          dyn_d = c_dyn;
          hit_d = c_hit_l | c_hit_r;
          if (c_miss_l || c_miss_r) begin
            x_d     = CENTER_X;
            y_d     = CENTER_Y;
            cnt_d   = SERVE_DELAY;
            state_d = ST_SERVE;
            // The next serve heads toward whoever just lost the point.
            if (c_miss_l) begin
              li_d  = (li_q == 3'd0) ? 3'd0 : li_q - 3'd1;
              dxn_d = 1'b1;
            end else begin
              ld_d  = (ld_q == 3'd0) ? 3'd0 : ld_q - 3'd1;
              dxn_d = 1'b0;
            end
            if ((c_miss_l && li_d == 3'd0) || (c_miss_r && ld_d == 3'd0))
              state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          li_d    = LIVES_INIT;
          ld_d    = LIVES_INIT;
          dxn_d   = 1'b0;
          dyn_d   = 1'b0;
          cnt_d   = SERVE_DELAY;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    go_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      x_q     <= CENTER_X;
      y_q     <= CENTER_Y;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      li_q    <= LIVES_INIT;
      ld_q    <= LIVES_INIT;
      go_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      li_q    <= li_d;
      ld_q    <= ld_d;
      go_q    <= go_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.posx      = x_q[9:0];
  assign bus.posy      = y_q[9:0];
  assign bus.vidasi    = li_q;
  assign bus.vidasd    = ld_q;
  assign bus.game_over = go_q;
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - randomized game against a frame-level reference model
module tb_pong_ball_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_OVER} mmode_t;

  mmode_t m_mode;
  int m_x, m_y, m_dx, m_dy, m_li, m_ld, m_wait;
  bit m_hit;
  int n_checks = 0;
  int n_fail = 0;
  int cov_hit = 0;
  int cov_bottom = 0;
  int cov_miss = 0;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_x = 314; m_y = 234; m_dx = 2; m_dy = 2;
    m_li = 7; m_ld = 7; m_wait = 0; m_hit = 0;
  endtask

  task automatic model_frame(input int pl, input int pr);
    int nx, ny;
    bit bl, br;
    nx = m_x + m_dx;
    ny = m_y + m_dy;
    if (ny <= 11) begin
      ny = 11; m_dy = 2;
    end else if (ny + 12 >= 469) begin
      ny = 457; m_dy = -2; cov_bottom++;
    end
    bl = (m_dx < 0) && (m_x > 40) && (nx <= 40) && (ny + 12 > pl) && (ny < pl + 100);
    br = (m_dx > 0) && (m_x + 12 < 600) && (nx + 12 >= 600) && (ny + 12 > pr) && (ny < pr + 100);
    if (bl) begin nx = 41; m_dx = 2; end
    if (br) begin nx = 587; m_dx = -2; end
    m_hit = bl || br;
    if (m_hit) cov_hit++;
    m_x = nx;
    m_y = ny;
    if ((!bl && nx <= 10) || (!br && nx + 12 >= 630)) begin
      cov_miss++;
      if (nx <= 10) begin
        m_li = (m_li > 0) ? m_li - 1 : 0; m_dx = -2;
      end else begin
        m_ld = (m_ld > 0) ? m_ld - 1 : 0; m_dx = 2;
      end
      m_x = 314; m_y = 234;
      if (m_li == 0 || m_ld == 0) m_mode = M_OVER;
      else begin m_mode = M_SERVE; m_wait = 60; end
    end
  endtask

  task automatic model_cycle(input bit tick, input bit st, input int pl, input int pr);
    m_hit = 0;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (st) begin
        if (m_mode == M_OVER) begin
          m_li = 7; m_ld = 7; m_dx = 2; m_dy = 2;
        end
        m_mode = M_SERVE; m_wait = 60;
      end
    end else if (tick) begin
      if (m_mode == M_SERVE) begin
        if (m_wait == 0) m_mode = M_PLAY;
        else m_wait--;
      end else begin
        model_frame(pl, pr);
      end
    end
  endtask

  function automatic logic [27:0] exp_vec();
    return {m_x[9:0], m_y[9:0], m_li[2:0], m_ld[2:0], (m_mode == M_OVER), m_hit};
  endfunction

  function automatic logic [27:0] act_vec();
    return {bus.posx, bus.posy, bus.vidasi, bus.vidasd, bus.game_over, bus.hit};
  endfunction

  function automatic string fmt(input logic [27:0] v);
    return $sformatf("x=%0d y=%0d li=%0d ld=%0d go=%0b hit=%0b",
                     v[27:18], v[17:8], v[7:5], v[4:2], v[1], v[0]);
  endfunction

  task automatic step(input bit tick, input bit st, input int pl, input int pr);
    @(negedge clk);
    bus.frame_tick = tick;
    bus.start = st;
    bus.posbarraiy = pl[9:0];
    bus.posbarrady = pr[9:0];
    @(posedge clk);
    model_cycle(tick, st, pl, pr);
    #1;
  endtask

  task automatic test_reset();
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.posbarraiy = 10'd200; bus.posbarrady = 10'd200;
    model_reset();
    #7;
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_hold: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 200, 200);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL idle_tick%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_serve();
    step(0, 1, 200, 200);
    for (int i = 0; i < 61; i++) begin
      step(1, 0, $urandom_range(0, 400), $urandom_range(0, 400));
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL serve_hold%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
    step(1, 0, 200, 200);
    n_checks++;
    if (bus.posx !== 10'd316 || bus.posy !== 10'd236) begin
      n_fail++; $display("FAIL first_move: got x=%0d y=%0d want x=316 y=236", bus.posx, bus.posy);
    end
  endtask

  task automatic test_random_game();
    int guard = 0;
    int pl, pr;
    bit tick, st;
    while (m_mode != M_OVER && guard < 40000) begin
      tick = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 30) == 0);
      pl = ($urandom_range(0, 9) < 4) ? ((m_y > 80) ? m_y - $urandom_range(0, 80) : 0)
                                      : $urandom_range(0, 400);
      pr = ($urandom_range(0, 9) < 4) ? ((m_y > 80) ? m_y - $urandom_range(0, 80) : 0)
                                      : $urandom_range(0, 400);
      step(tick, st, pl, pr);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL game_cycle%0d: got %s want %s", guard, fmt(act_vec()), fmt(exp_vec()));
      end
      guard++;
    end
    n_checks++;
    if (guard >= 40000 || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL game_end: got game_over=%0b after %0d cycles want 1", bus.game_over, guard);
    end
    n_checks++;
    if (cov_hit == 0 || cov_bottom == 0 || cov_miss < 7) begin
      n_fail++; $display("FAIL game_coverage: got hits=%0d bottom=%0d misses=%0d want >0 >0 >=7",
                         cov_hit, cov_bottom, cov_miss);
    end
  endtask

  task automatic test_restart();
    step(1, 0, 200, 200);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL over_hold: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
    step(0, 1, 200, 200);
    n_checks++;
    if (bus.vidasi !== 3'd7 || bus.vidasd !== 3'd7 || bus.game_over !== 1'b0) begin
      n_fail++; $display("FAIL restart: got li=%0d ld=%0d go=%0b want 7 7 0",
                         bus.vidasi, bus.vidasd, bus.game_over);
    end
    for (int i = 0; i < 61; i++) step(1, 0, 200, 200);
    step(1, 0, 200, 200);
    n_checks++;
    if (bus.posx !== 10'd316 || bus.posy !== 10'd236) begin
      n_fail++; $display("FAIL restart_move: got x=%0d y=%0d want x=316 y=236", bus.posx, bus.posy);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 200, 200);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL restart_play%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.frame_tick = 1'b1; bus.start = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_ignore%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 200, 200);
    step(0, 1, 200, 200);
    for (int i = 0; i < 62; i++) step(1, 0, 200, 200);
    n_checks++;
    if (bus.posx !== 10'd316 || bus.posy !== 10'd236 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset_move: got %s want x=316 y=236", fmt(act_vec()));
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_random_game();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
